// File: rtl/pc_redirect_unit.sv
// Program counter owner for the jump-register decode path: picks the next PC
// (jr / jump / taken branch / sequential) and raises a fixed-length flush on redirect.
module pc_redirect_unit #(
   parameter int unsigned         PC_WIDTH     = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
   parameter int unsigned         FLUSH_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic                JR_control,
   input  logic                jump,
   input  logic                branch,
   input  logic                zero,
   input  logic [PC_WIDTH-1:0] jr_target,
   input  logic [PC_WIDTH-1:0] jump_target,
   input  logic [PC_WIDTH-1:0] branch_offset,
   output logic [PC_WIDTH-1:0] pc,
   output logic                flush,
   output logic                redirect,
   output logic                o_dbg_state
);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   localparam logic [3:0] LP_CNT_INIT = 4'(FLUSH_CYCLES - 1);

   state_t              r_state;
   logic [PC_WIDTH-1:0] r_pc;
   logic [3:0]          r_cnt;
   logic                r_flush;
   logic                r_redirect;

   state_t              w_state_nx;
   logic [PC_WIDTH-1:0] w_pc_nx;
   logic [3:0]          w_cnt_nx;
   logic                w_flush_nx;
   logic                w_redirect_nx;
   logic [PC_WIDTH-1:0] w_pc_inc;
   logic [PC_WIDTH-1:0] w_br_target;
   logic [PC_WIDTH-1:0] w_target;
   logic                w_take;

   // Request handshake: a transfer flag is a request valid for as long as it is
   // high; it is accepted only on an unstalled edge while in RUN, so control must
   // hold it through stall. Requests seen in FLUSH belong to squashed instructions.
   always_comb begin
      w_pc_inc    = r_pc + PC_WIDTH'(1);
      w_br_target = w_pc_inc + branch_offset;
      w_take      = JR_control | jump | (branch & zero);
      if (JR_control) begin
         w_target = jr_target;
      end else if (jump) begin
         w_target = jump_target;
      end else begin
         w_target = w_br_target;
      end
   end

   always_comb begin
      w_state_nx    = r_state;
      w_pc_nx       = r_pc;
      w_cnt_nx      = r_cnt;
      w_flush_nx    = r_flush;
      w_redirect_nx = 1'b0;
      if (!stall) begin
         case (r_state)
            ST_RUN: begin
               if (w_take) begin
                  w_pc_nx       = w_target;
                  w_redirect_nx = 1'b1;
                  w_flush_nx    = 1'b1;
                  w_cnt_nx      = LP_CNT_INIT;
                  w_state_nx    = ST_FLUSH;
               end else begin
                  w_pc_nx    = w_pc_inc;
                  w_flush_nx = 1'b0;
               end
            end
            ST_FLUSH: begin
               w_pc_nx = w_pc_inc;
               if (r_cnt == 4'd0) begin
                  w_flush_nx = 1'b0;
                  w_state_nx = ST_RUN;
               end else begin
                  w_cnt_nx = r_cnt - 4'd1;
               end
            end
            default: begin
               w_state_nx = ST_RUN;
               w_flush_nx = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_RUN;
         r_pc       <= RESET_PC;
         r_cnt      <= 4'd0;
         r_flush    <= 1'b0;
         r_redirect <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_pc       <= w_pc_nx;
         r_cnt      <= w_cnt_nx;
         r_flush    <= w_flush_nx;
         r_redirect <= w_redirect_nx;
      end
   end

   assign pc          = r_pc;
   assign flush       = r_flush;
   assign redirect    = r_redirect;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: a cycle-by-cycle vector table plus hand
// sequences comparing FLUSH_CYCLES=2 and FLUSH_CYCLES=1 instances.
module tb_pc_redirect_unit;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        jr_c;
   logic        jump;
   logic        branch;
   logic        zero;
   logic [15:0] jr_target;
   logic [15:0] jump_target;
   logic [15:0] branch_offset;

   logic [15:0] pc_a, pc_b;
   logic        flush_a, flush_b;
   logic        redir_a, redir_b;
   logic        st_a, st_b;

   int n_tests;
   int n_fail;

   pc_redirect_unit #(.PC_WIDTH(16), .RESET_PC(16'h0000), .FLUSH_CYCLES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .JR_control(jr_c), .jump(jump),
      .branch(branch), .zero(zero), .jr_target(jr_target), .jump_target(jump_target),
      .branch_offset(branch_offset), .pc(pc_a), .flush(flush_a), .redirect(redir_a),
      .o_dbg_state(st_a)
   );

   pc_redirect_unit #(.PC_WIDTH(16), .RESET_PC(16'h0000), .FLUSH_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .JR_control(jr_c), .jump(jump),
      .branch(branch), .zero(zero), .jr_target(jr_target), .jump_target(jump_target),
      .branch_offset(branch_offset), .pc(pc_b), .flush(flush_b), .redirect(redir_b),
      .o_dbg_state(st_b)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        rn;
      logic        st;
      logic        jr;
      logic        jmp;
      logic        br;
      logic        z;
      logic [15:0] jrt;
      logic [15:0] jt;
      logic [15:0] off;
      logic [15:0] e_pc;
      logic        e_fl;
      logic        e_rd;
   } vec_t;

   vec_t vecs[64];
   int   n_vec;

   task automatic add(input logic rn, input logic st, input logic jr, input logic jmp,
                      input logic br, input logic z, input logic [15:0] jrt,
                      input logic [15:0] jt, input logic [15:0] off,
                      input logic [15:0] e_pc, input logic e_fl, input logic e_rd);
      vecs[n_vec].rn   = rn;
      vecs[n_vec].st   = st;
      vecs[n_vec].jr   = jr;
      vecs[n_vec].jmp  = jmp;
      vecs[n_vec].br   = br;
      vecs[n_vec].z    = z;
      vecs[n_vec].jrt  = jrt;
      vecs[n_vec].jt   = jt;
      vecs[n_vec].off  = off;
      vecs[n_vec].e_pc = e_pc;
      vecs[n_vec].e_fl = e_fl;
      vecs[n_vec].e_rd = e_rd;
      n_vec++;
   endtask

   // driver
   task automatic drive(input logic rn, input logic st, input logic jr, input logic jmp,
                        input logic br, input logic z, input logic [15:0] jrt,
                        input logic [15:0] jt, input logic [15:0] off);
      rst_n         = rn;
      stall         = st;
      jr_c          = jr;
      jump          = jmp;
      branch        = br;
      zero          = z;
      jr_target     = jrt;
      jump_target   = jt;
      branch_offset = off;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // scoreboard compare
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      n_vec   = 0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);

      //   rn st jr jm br z   jrt      jt       off      e_pc     fl rd
      // reset and sequential count
      add(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
      add(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 0, 0);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 0, 0);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 0, 0);
      // reach pc=0x0010 in RUN, then jr beats jump and branch
      add(1, 0, 0, 1, 0, 0, 16'h0000, 16'h000E, 16'h0000, 16'h000E, 1, 1);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h000F, 1, 0);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 0, 0);
      add(1, 0, 1, 1, 1, 1, 16'h0400, 16'h0200, 16'h0005, 16'h0400, 1, 1);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0401, 1, 0);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0402, 0, 0);
      // reach pc=0x0005, backward branch, then untaken branch
      add(1, 0, 0, 1, 0, 0, 16'h0000, 16'h0003, 16'h0000, 16'h0003, 1, 1);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 1, 0);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0005, 0, 0);
      add(1, 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 16'hFFFD, 16'h0003, 1, 1);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 1, 0);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0005, 0, 0);
      add(1, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'hFFFD, 16'h0006, 0, 0);
      // sequential wrap 0xFFFF -> 0x0000
      add(1, 0, 0, 1, 0, 0, 16'h0000, 16'hFFFD, 16'h0000, 16'hFFFD, 1, 1);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFE, 1, 0);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 0, 0);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
      // requests during FLUSH are ignored
      add(1, 0, 0, 1, 0, 0, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 1, 1);
      add(1, 0, 1, 0, 0, 0, 16'h0999, 16'h0000, 16'h0000, 16'h0101, 1, 0);
      add(1, 0, 1, 0, 0, 0, 16'h0999, 16'h0000, 16'h0000, 16'h0102, 0, 0);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0103, 0, 0);
      // stall in first flush cycle
      add(1, 0, 0, 1, 0, 0, 16'h0000, 16'h0020, 16'h0000, 16'h0020, 1, 1);
      add(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0020, 1, 0);
      add(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0020, 1, 0);
      add(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0020, 1, 0);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0021, 1, 0);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0022, 0, 0);
      // jump held across a stall in RUN
      add(1, 1, 0, 1, 0, 0, 16'h0000, 16'h0300, 16'h0000, 16'h0022, 0, 0);
      add(1, 1, 0, 1, 0, 0, 16'h0000, 16'h0300, 16'h0000, 16'h0022, 0, 0);
      add(1, 0, 0, 1, 0, 0, 16'h0000, 16'h0300, 16'h0000, 16'h0300, 1, 1);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0301, 1, 0);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0302, 0, 0);
      // forward branch
      add(1, 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 16'h0010, 16'h0313, 1, 1);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0314, 1, 0);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0315, 0, 0);
      // back-to-back: request on the cycle FLUSH ends, taken one cycle later
      add(1, 0, 0, 1, 0, 0, 16'h0000, 16'h0050, 16'h0000, 16'h0050, 1, 1);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0051, 1, 0);
      add(1, 0, 0, 1, 0, 0, 16'h0000, 16'h0060, 16'h0000, 16'h0052, 0, 0);
      add(1, 0, 0, 1, 0, 0, 16'h0000, 16'h0060, 16'h0000, 16'h0060, 1, 1);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0061, 1, 0);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0062, 0, 0);
      // reset in second flush cycle overrides stall and request
      add(1, 0, 0, 1, 0, 0, 16'h0000, 16'h0700, 16'h0000, 16'h0700, 1, 1);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0701, 1, 0);
      add(0, 1, 1, 0, 0, 0, 16'h0999, 16'h0000, 16'h0000, 16'h0000, 0, 0);
      add(1, 0, 0, 1, 0, 0, 16'h0000, 16'h00AB, 16'h0000, 16'h00AB, 1, 1);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h00AC, 1, 0);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h00AD, 0, 0);

      for (int i = 0; i < n_vec; i++) begin
         drive(vecs[i].rn, vecs[i].st, vecs[i].jr, vecs[i].jmp, vecs[i].br, vecs[i].z,
               vecs[i].jrt, vecs[i].jt, vecs[i].off);
         tick();
         chk($sformatf("v%0d pc", i), 32'(pc_a), 32'(vecs[i].e_pc));
         chk($sformatf("v%0d flush", i), 32'(flush_a), 32'(vecs[i].e_fl));
         chk($sformatf("v%0d redirect", i), 32'(redir_a), 32'(vecs[i].e_rd));
         chk($sformatf("v%0d state", i), 32'(st_a), 32'(vecs[i].e_fl));
      end

      // FLUSH_CYCLES=1 instance against the default one on the jr case
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      tick();
      tick();
      chk("fc1 reset pc", 32'(pc_b), 32'h0000);
      chk("fc1 reset flush", 32'(flush_b), 32'h0);
      chk("fc1 reset state", 32'(st_b), 32'h0);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0400, 16'h0200, 16'h0000);
      tick();
      chk("fc1 jr pc", 32'(pc_b), 32'h0400);
      chk("fc1 jr flush", 32'(flush_b), 32'h1);
      chk("fc1 jr redirect", 32'(redir_b), 32'h1);
      chk("fc2 jr pc", 32'(pc_a), 32'h0400);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      tick();
      chk("fc1 post pc", 32'(pc_b), 32'h0401);
      chk("fc1 post flush", 32'(flush_b), 32'h0);
      chk("fc1 post redirect", 32'(redir_b), 32'h0);
      chk("fc2 post flush", 32'(flush_a), 32'h1);
      tick();
      chk("fc1 end pc", 32'(pc_b), 32'h0402);
      chk("fc1 end state", 32'(st_b), 32'h0);
      chk("fc2 end flush", 32'(flush_a), 32'h0);

      // final report
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Consumer end of the jump-register decode path. Takes the per-instruction JR_control flag, together with the jump and branch flags from the main control.
- Owns the program counter register and selects the next PC.
- On any taken control transfer, raises a fixed-length pipeline flush so that wrong-path instructions are squashed.
- Sits between control/decode and the instruction-memory address port.

Parameters:
- PC_WIDTH, 16, width of PC and of all target/offset buses
- RESET_PC, 0, PC value loaded on reset
- FLUSH_CYCLES, 2, number of cycles flush stays high after a redirect (legal range 1..15)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- stall  input  1  freeze: PC, FSM and flush counter hold their values
- JR_control  input  1  current instruction is jr; target comes from register
- jump  input  1  current instruction is an absolute jump
- branch  input  1  current instruction is a conditional branch
- zero  input  1  ALU zero flag; branch is taken when branch=1 and zero=1
- jr_target  input  PC_WIDTH  register-file value for jr
- jump_target  input  PC_WIDTH  absolute jump address
- branch_offset  input  PC_WIDTH  two's-complement word offset
- pc  output  PC_WIDTH  current PC (registered)
- flush  output  1  squash wrong-path instructions (registered)
- redirect  output  1  one-cycle pulse on the cycle a transfer is accepted (registered)

Behaviour:
- Reset (rst_n=0 at a clock edge): pc=RESET_PC, flush=0, redirect=0, FSM=RUN, counter=0. Reset overrides stall and every request, including when it lands in the middle of FLUSH.
- Sequential PC: pc_next = pc + 1, modulo 2^PC_WIDTH. 0xFFFF wraps to 0x0000 with no flag.
- Branch target: pc + 1 + branch_offset, modulo 2^PC_WIDTH. The offset is used as signed; the carry is discarded.
- Redirect priority, applied in RUN only: JR_control > jump > (branch & zero) > sequential.
  - JR_control=1 wins even when jump or branch is also set.
- FSM state RUN, with stall=0:
  - If any transfer is taken: pc <= selected target, redirect <= 1, flush <= 1, counter <= FLUSH_CYCLES-1, next state FLUSH. If FLUSH_CYCLES=1, the counter is 0.
  - Otherwise: pc <= pc+1, redirect <= 0, flush <= 0.
- FSM state FLUSH, with stall=0:
  - pc <= pc+1, so fetch continues from the target.
  - redirect <= 0.
  - JR_control, jump and branch are ignored, because they come from squashed instructions.
  - If counter=0: flush <= 0, next state RUN. Otherwise counter <= counter-1 and flush stays 1.
  - flush is therefore high for exactly FLUSH_CYCLES consecutive unstalled cycles per redirect.
- stall=1, in either state:
  - All registers hold: pc, state, counter, flush.
  - redirect <= 0, so the pulse is never stretched.
  - Requests presented during stall are not latched. Control must hold them until stall drops.
- Request and stall in the same cycle: the request is not accepted. It is accepted on the first cycle with stall=0, provided the FSM is in RUN.
- Back-to-back: a request on the cycle FLUSH returns to RUN is evaluated on the following cycle, which is the first cycle in RUN.
- Latency: target visible on pc one cycle after the accepting edge. redirect and flush rise in that same cycle.
- Combinational inputs (JR_control etc.) are only sampled at the clock edge; there is no combinational path from any input to any output.

Test Plan:
- Reset/sequential: rst_n=0 for 2 cycles, then 1, with no requests -> pc=0x0000,0x0001,0x0002,0x0003; flush=0, redirect=0 throughout.
- jr priority: at pc=0x0010, assert JR_control=1, jump=1, branch=1, zero=1, jr_target=0x0400, jump_target=0x0200 for one cycle -> next pc=0x0400, redirect=1 for 1 cycle, flush=1 for 2 cycles, pc then 0x0401, 0x0402.
- Branch arithmetic and wrap: at pc=0x0005, branch=1, zero=1, offset=0xFFFD (-3) -> pc=0x0003. Separately, sequential from pc=0xFFFF -> pc=0x0000. Also branch=1, zero=0 -> pc=0x0006.
- Requests ignored in FLUSH: jump to 0x0100, then assert JR_control with jr_target=0x0999 in both flush cycles -> pc=0x0100, 0x0101, 0x0102; no second redirect pulse.
- Stall: assert stall=1 for 3 cycles in the first flush cycle after a jump to 0x0020 -> pc holds 0x0020 and flush holds 1 during the stall. After release, flush stays 1 for one more cycle, so 2 unstalled flush cycles total. A jump held across a stall in RUN is accepted on the first unstalled edge.
- Reset mid-flush: rst_n=0 in the second flush cycle -> next edge pc=RESET_PC, flush=0, redirect=0, FSM in RUN. With FLUSH_CYCLES=1, rerun the jr case -> flush is high for exactly 1 cycle.
